// File: rtl/parity_frame_rx_if.sv
// Bundle between the serial front end / word consumer and parity_frame_rx.
// master = link/consumer side, slave = the receiver itself.
interface parity_frame_rx_if #(
  parameter int DATA_BITS = 3,
  parameter int CNT_W     = 8
);
  logic                 bit_valid;
  logic                 bit_in;
  logic                 busy;
  logic                 frame_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] frame_data;
  logic                 parity_err;
  logic [CNT_W-1:0]     err_count;

  modport master (
    output bit_valid, bit_in, out_ready,
    input  busy, frame_valid, frame_data, parity_err, err_count
  );

  modport slave (
    input  bit_valid, bit_in, out_ready,
    output busy, frame_valid, frame_data, parity_err, err_count
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Even-parity serial frame receiver: DATA_BITS data bits (MSB first) + parity bit,
// valid/ready output. Optional saturating error counter under PARITY_ERR_COUNT_EN.
module parity_frame_rx #(
  parameter int DATA_BITS = 3,
  parameter int CNT_W     = 8
) (
  input  logic               clock,
  input  logic               reset_b,
  parity_frame_rx_if.slave   bus
);
  localparam int CW = $clog2(DATA_BITS + 2);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 fv_q, fv_d;
  logic                 busy_q, busy_d;
  logic                 handshake;
  logic [DATA_BITS-1:0] shifted;

  assign handshake = fv_q & bus.out_ready;
  assign shifted   = {shift_q[DATA_BITS-2:0], bus.bit_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shift_d = shift_q;
    data_d  = data_q;
    perr_d  = perr_q;
    fv_d    = fv_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.bit_valid) begin
          shift_d = shifted;
          acc_d   = bus.bit_in;
          cnt_d   = CW'(1);
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (bus.bit_valid) begin
          acc_d = acc_q ^ bus.bit_in;
          cnt_d = cnt_q + CW'(1);
          // cnt_q == DATA_BITS means this is the parity bit: not shifted
          if (cnt_q == LAST_DATA) begin
            state_d = S_HOLD;
            data_d  = shift_q;
            perr_d  = acc_q ^ bus.bit_in;
            fv_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            shift_d = shifted;
          end
        end
      end
      S_HOLD: begin
        if (handshake) begin
          state_d = S_IDLE;
          fv_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      fv_q    <= fv_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_data  = data_q;
  assign bus.parity_err  = perr_q;

`ifdef PARITY_ERR_COUNT_EN
  logic [CNT_W-1:0] errc_q, errc_d;

  always_comb begin
    errc_d = errc_q;
    if ((state_q == S_HOLD) && handshake && perr_q && (errc_q != '1))
      errc_d = errc_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) errc_q <= '0;
    else          errc_q <= errc_d;
  end

  assign bus.err_count = errc_q;
`else
  assign bus.err_count = '0;
`endif

  a_busy_fv: assert property (@(posedge clock) disable iff (!reset_b) busy_q == fv_q);
  a_hold_fv: assert property (@(posedge clock) disable iff (!reset_b) fv_q == (state_q == S_HOLD));

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomized + directed bench for parity_frame_rx against a bit-queue frame model.
module tb_parity_frame_rx;
  localparam int DB   = 3;
  localparam int CW   = 2;
  localparam int EMAX = (1 << CW) - 1;

  logic clock   = 1'b0;
  logic reset_b = 1'b0;
  always #5 clock = ~clock;

  parity_frame_rx_if #(.DATA_BITS(DB), .CNT_W(CW)) bus();

  parity_frame_rx #(.DATA_BITS(DB), .CNT_W(CW)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: collect bits of the current frame; a full frame becomes the held result.
  bit            mq[$];
  bit            m_hold;
  logic [DB-1:0] m_data;
  bit            m_perr;
  int            m_errs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_hold = 1'b0;
    m_data = '0;
    m_perr = 1'b0;
    m_errs = 0;
  endtask

  task automatic model_step(input bit bv, input bit b, input bit rdy);
    if (m_hold) begin
      if (rdy) begin
        m_hold = 1'b0;
        if (m_perr && m_errs < EMAX) m_errs++;
      end
    end else if (bv) begin
      mq.push_back(b);
      if (mq.size() == DB + 1) begin
        m_perr = 1'b0;
        foreach (mq[i]) m_perr ^= mq[i];
        for (int i = 0; i < DB; i++) m_data[DB-1-i] = mq[i];
        m_hold = 1'b1;
        mq.delete();
      end
    end
  endtask

  function automatic int exp_cnt();
`ifdef PARITY_ERR_COUNT_EN
    return m_errs;
`else
    return 0;
`endif
  endfunction

  task automatic check_all();
    chk("busy",        32'(bus.busy),        32'(m_hold));
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_hold));
    chk("frame_data",  32'(bus.frame_data),  32'(m_data));
    chk("parity_err",  32'(bus.parity_err),  32'(m_perr));
    chk("err_count",   32'(bus.err_count),   32'(exp_cnt()));
  endtask

  task automatic cyc(input bit bv, input bit b, input bit rdy);
    bus.bit_valid = bv;
    bus.bit_in    = b;
    bus.out_ready = rdy;
    @(posedge clock);
    model_step(bv, b, rdy);
    #1;
    check_all();
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input bit rdy);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, v[i], rdy);
  endtask

  task automatic pulse_reset();
    reset_b = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    reset_b = 1'b1;
  endtask

  int sat_exp[5];

  initial begin
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // reset held 3 cycles, then idle
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_all();
    end
    reset_b = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);

    // good frame, back-to-back, ready high
    send_bits(16'b1010, 4, 1'b1);
    chk("good_data", 32'(bus.frame_data), 32'(3'b101));
    chk("good_perr", 32'(bus.parity_err), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("good_fv_drop", 32'(bus.frame_valid), 32'd0);

    // bad frame with backpressure and bits offered during HOLD
    send_bits(16'b1110, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(i != 0, i[0], 1'b0);
      chk("bp_data", 32'(bus.frame_data), 32'(3'b111));
      chk("bp_perr", 32'(bus.parity_err), 32'd1);
    end
    cyc(1'b1, 1'b1, 1'b1);
`ifdef PARITY_ERR_COUNT_EN
    chk("bp_errcnt", 32'(bus.err_count), 32'd1);
`else
    chk("bp_errcnt", 32'(bus.err_count), 32'd0);
`endif

    // gaps inside a frame
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("gap_data", 32'(bus.frame_data), 32'(3'b011));
    chk("gap_perr", 32'(bus.parity_err), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    send_bits(16'b0000, 4, 1'b1);
    chk("zero_data", 32'(bus.frame_data), 32'(3'b000));
    chk("zero_perr", 32'(bus.parity_err), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);

    // saturation
    pulse_reset();
`ifdef PARITY_ERR_COUNT_EN
    sat_exp = '{1, 2, 3, 3, 3};
`else
    sat_exp = '{0, 0, 0, 0, 0};
`endif
    for (int f = 0; f < 5; f++) begin
      send_bits(16'b1110, 4, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("sat_errcnt", 32'(bus.err_count), 32'(sat_exp[f]));
    end

    // mid-frame reset discards the partial frame
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    pulse_reset();
    send_bits(16'b0110, 4, 1'b1);
    chk("abort_data", 32'(bus.frame_data), 32'(3'b011));
    chk("abort_perr", 32'(bus.parity_err), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      cyc($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
